// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU/branch selects and the control bundle.
package decode_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LB   = 4'b0010;
  localparam logic [3:0] OP_SB   = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_ANDI = 4'b0110;
  localparam logic [3:0] OP_ORI  = 4'b0111;
  localparam logic [3:0] OP_ALU  = 4'b1111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_BR2  = 4'b1010;
  localparam logic [3:0] OP_BR3  = 4'b1011;

  // Function code in INST[2:0] that turns opcode 0000 into HALT.
  localparam logic [2:0] HALT_FN = 3'b001;

  localparam logic [2:0] FS_ADD = 3'd0;
  localparam logic [2:0] FS_SUB = 3'd1;
  localparam logic [2:0] FS_AND = 3'd5;
  localparam logic [2:0] FS_OR  = 3'd6;

  localparam logic [2:0] BS_BEQ  = 3'd0;
  localparam logic [2:0] BS_BNE  = 3'd1;
  localparam logic [2:0] BS_BR2  = 3'd2;
  localparam logic [2:0] BS_BR3  = 3'd3;
  localparam logic [2:0] BS_NONE = 3'd4;

  // Width-independent control signals; register/immediate fields travel separately.
  typedef struct packed {
    logic       mb;
    logic       md;
    logic       ld;
    logic       mw;
    logic [2:0] fs;
    logic [2:0] bs;
    logic       halt;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_EMPTY = '{mb: 1'b0, md: 1'b0, ld: 1'b0, mw: 1'b0,
                                   fs: 3'd0, bs: BS_NONE, halt: 1'b0, illegal: 1'b0};

  // LB is the only opcode that selects memory data into the register file.
  function automatic logic is_lb(ctrl_t c);
    return c.md & c.ld;
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake plus decoded control outputs.
interface decode_if #(
  parameter int REG_AW = 3,
  parameter int IMM_W  = 6
);
  localparam int INST_W = 4 + 2*REG_AW + IMM_W;

  logic              IN_VALID;
  logic              IN_READY;
  logic [INST_W-1:0] INST;
  logic              FLUSH;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [REG_AW-1:0] DR, SA, SB;
  logic [IMM_W-1:0]  IMM, OFF;
  logic              MB, MD, LD, MW;
  logic [2:0]        FS, BS;
  logic              HALT, HALTED, ILLEGAL;

  // Decode stage side.
  modport slave (
    input  IN_VALID, INST, FLUSH, OUT_READY,
    output IN_READY, OUT_VALID, DR, SA, SB, IMM, OFF,
           MB, MD, LD, MW, FS, BS, HALT, HALTED, ILLEGAL
  );

  // Fetch/execute (or bench) side.
  modport master (
    output IN_VALID, INST, FLUSH, OUT_READY,
    input  IN_READY, OUT_VALID, DR, SA, SB, IMM, OFF,
           MB, MD, LD, MW, FS, BS, HALT, HALTED, ILLEGAL
  );
endinterface

// File: rtl/decode_comb.sv
// Combinational instruction decoder: INST -> control bundle, register/immediate
// fields and which source registers the instruction reads.
// Optional: DECODE_ILLEGAL_TRAP_EN flags unlisted opcodes as illegal.
module decode_comb
  import decode_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int IMM_W  = 6,
  localparam int INST_W = 4 + 2*REG_AW + IMM_W
) (
  input  logic [INST_W-1:0] inst_i,
  output ctrl_t             ctrl_o,
  output logic [REG_AW-1:0] dr_o,
  output logic [REG_AW-1:0] sa_o,
  output logic [REG_AW-1:0] sb_o,
  output logic [IMM_W-1:0]  imm_o,
  output logic [IMM_W-1:0]  off_o,
  output logic              rd_sa_o,
  output logic              rd_sb_o
);

  logic [3:0]        op;
  logic [REG_AW-1:0] f_sa, f_sb;
  logic [IMM_W-1:0]  f_imm;

  assign op    = inst_i[INST_W-1 -: 4];
  assign f_sa  = inst_i[INST_W-5 -: REG_AW];
  assign f_sb  = inst_i[INST_W-5-REG_AW -: REG_AW];
  assign f_imm = inst_i[IMM_W-1:0];

  // Opcode decode; every field not used by the opcode stays 0.
  always_comb begin
    ctrl_o  = CTRL_EMPTY;
    dr_o    = '0;
    sa_o    = '0;
    sb_o    = '0;
    imm_o   = '0;
    off_o   = '0;
    rd_sa_o = 1'b0;
    rd_sb_o = 1'b0;
    case (op)
      OP_NOP: ctrl_o.halt = (inst_i[2:0] == HALT_FN);
      OP_LB: begin
        ctrl_o.mb = 1'b1; ctrl_o.md = 1'b1; ctrl_o.ld = 1'b1;
        dr_o = f_sb; sa_o = f_sa; imm_o = f_imm; rd_sa_o = 1'b1;
      end
      OP_SB: begin
        ctrl_o.mb = 1'b1; ctrl_o.mw = 1'b1;
        sa_o = f_sa; sb_o = f_sb; imm_o = f_imm;
        rd_sa_o = 1'b1; rd_sb_o = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        ctrl_o.mb = 1'b1; ctrl_o.ld = 1'b1;
        ctrl_o.fs = (op == OP_ANDI) ? FS_AND : (op == OP_ORI) ? FS_OR : FS_ADD;
        dr_o = f_sb; sa_o = f_sa; imm_o = f_imm; rd_sa_o = 1'b1;
      end
      OP_ALU: begin
        // R-type keeps DR and the function code inside the immediate field.
        ctrl_o.ld = 1'b1;
        ctrl_o.fs = inst_i[2:0];
        dr_o = f_imm[REG_AW+2:3]; sa_o = f_sa; sb_o = f_sb;
        rd_sa_o = 1'b1; rd_sb_o = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl_o.bs = (op == OP_BEQ) ? BS_BEQ : BS_BNE;
        ctrl_o.fs = FS_SUB;
        sa_o = f_sa; sb_o = f_sb; off_o = f_imm;
        rd_sa_o = 1'b1; rd_sb_o = 1'b1;
      end
      OP_BR2, OP_BR3: begin
        // Sign test against zero: B-mux picks the (zero) immediate.
        ctrl_o.bs = (op == OP_BR2) ? BS_BR2 : BS_BR3;
        ctrl_o.mb = 1'b1;
        sa_o = f_sa; off_o = f_imm; rd_sa_o = 1'b1;
      end
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        ctrl_o.illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: one pipeline slot with valid/ready on both sides,
// load-use interlock bubble, sticky halt and branch flush.
// Optional: DECODE_ILLEGAL_TRAP_EN makes unlisted opcodes trap like HALT.
// IMM_W must be at least REG_AW+3 so the R-type DR field fits in the immediate.
module decode_stage
  import decode_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int IMM_W  = 6
) (
  input  logic    CLK,
  input  logic    RESET_N,
  decode_if.slave bus
);

  ctrl_t             dec_ctrl;
  logic [REG_AW-1:0] dec_dr, dec_sa, dec_sb;
  logic [IMM_W-1:0]  dec_imm, dec_off;
  logic              dec_rd_sa, dec_rd_sb;

  decode_comb #(.REG_AW(REG_AW), .IMM_W(IMM_W)) u_dec (
    .inst_i  (bus.INST),
    .ctrl_o  (dec_ctrl),
    .dr_o    (dec_dr),
    .sa_o    (dec_sa),
    .sb_o    (dec_sb),
    .imm_o   (dec_imm),
    .off_o   (dec_off),
    .rd_sa_o (dec_rd_sa),
    .rd_sb_o (dec_rd_sb)
  );

  logic              vld_q, vld_d;
  logic              halted_q, halted_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [REG_AW-1:0] dr_q, dr_d, sa_q, sa_d, sb_q, sb_d;
  logic [IMM_W-1:0]  imm_q, imm_d, off_q, off_d;

  logic interlock, in_ready, accept, trap;

  // Load-use hazard: the loaded register is not ready for a reader in the very
  // next slot. Register 0 is never a real destination, so it never stalls.
  assign interlock = vld_q & is_lb(ctrl_q) & (dr_q != '0) &
                     ((dec_rd_sa & (dec_sa == dr_q)) | (dec_rd_sb & (dec_sb == dr_q)));
  assign in_ready  = ~halted_q & ~bus.FLUSH & ~interlock & (~vld_q | bus.OUT_READY);
  assign accept    = bus.IN_VALID & in_ready;
  assign trap      = dec_ctrl.halt | dec_ctrl.illegal;

  // Slot next state: flush beats acceptance, acceptance beats plain drain.
  always_comb begin
    vld_d    = vld_q;
    halted_d = halted_q;
    ctrl_d   = ctrl_q;
    dr_d     = dr_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    imm_d    = imm_q;
    off_d    = off_q;
    if (bus.FLUSH) begin
      vld_d = 1'b0;
      // A halt that was only speculative is squashed together with the slot.
      if (vld_q & (ctrl_q.halt | ctrl_q.illegal)) halted_d = 1'b0;
    end else if (accept) begin
      vld_d  = 1'b1;
      ctrl_d = dec_ctrl;
      dr_d   = dec_dr;
      sa_d   = dec_sa;
      sb_d   = dec_sb;
      imm_d  = dec_imm;
      off_d  = dec_off;
      if (trap) halted_d = 1'b1;
    end else if (vld_q & bus.OUT_READY) begin
      vld_d = 1'b0;
    end
  end

  // Slot and halt state registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vld_q    <= 1'b0;
      halted_q <= 1'b0;
      ctrl_q   <= CTRL_EMPTY;
      dr_q     <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      imm_q    <= '0;
      off_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      halted_q <= halted_d;
      ctrl_q   <= ctrl_d;
      dr_q     <= dr_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      imm_q    <= imm_d;
      off_q    <= off_d;
    end
  end

  // An empty slot always presents the inert bundle so no stray write escapes.
  ctrl_t ctrl_out;
  assign ctrl_out = vld_q ? ctrl_q : CTRL_EMPTY;

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = vld_q;
  assign bus.DR        = vld_q ? dr_q  : '0;
  assign bus.SA        = vld_q ? sa_q  : '0;
  assign bus.SB        = vld_q ? sb_q  : '0;
  assign bus.IMM       = vld_q ? imm_q : '0;
  assign bus.OFF       = vld_q ? off_q : '0;
  assign bus.MB        = ctrl_out.mb;
  assign bus.MD        = ctrl_out.md;
  assign bus.LD        = ctrl_out.ld;
  assign bus.MW        = ctrl_out.mw;
  assign bus.FS        = ctrl_out.fs;
  assign bus.BS        = ctrl_out.bs;
  assign bus.HALT      = ctrl_out.halt;
  assign bus.ILLEGAL   = ctrl_out.illegal;
  assign bus.HALTED    = halted_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: expected slot contents are queued when
// an instruction is accepted and compared when the slot presents it.
module tb_decode_stage;

  typedef struct packed {
    logic [2:0] dr, sa, sb;
    logic [5:0] imm, off;
    logic       mb, md, ld, mw;
    logic [2:0] fs, bs;
    logic       halt, ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  exp_t act, ex1;

  always #5 clk = ~clk;

  decode_if #(.REG_AW(3), .IMM_W(6)) bus ();
  decode_stage #(.REG_AW(3), .IMM_W(6)) dut (.CLK(clk), .RESET_N(rst_n), .bus(bus));

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  // ctl = {mb, md, ld, mw}
  function automatic exp_t mk(logic [2:0] dr, logic [2:0] sa, logic [2:0] sb,
                              logic [5:0] imm, logic [5:0] off, logic [3:0] ctl,
                              logic [2:0] fs, logic [2:0] bs, logic halt, logic ill);
    exp_t r;
    r = '{dr: dr, sa: sa, sb: sb, imm: imm, off: off, mb: ctl[3], md: ctl[2],
          ld: ctl[1], mw: ctl[0], fs: fs, bs: bs, halt: halt, ill: ill};
    return r;
  endfunction

  function automatic exp_t obs();
    exp_t r;
    r = '{dr: bus.DR, sa: bus.SA, sb: bus.SB, imm: bus.IMM, off: bus.OFF, mb: bus.MB,
          md: bus.MD, ld: bus.LD, mw: bus.MW, fs: bus.FS, bs: bus.BS, halt: bus.HALT,
          ill: bus.ILLEGAL};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins);
    bus.IN_VALID = v;
    bus.INST     = ins;
  endtask

  task automatic test_reset();
    exp_t empty;
    empty = mk(0, 0, 0, 0, 0, 4'b0000, 0, 3'd4, 0, 0);
    rst_n = 1'b0;
    drive(0, 16'h0); bus.FLUSH = 1'b0; bus.OUT_READY = 1'b1;
    tick(); #1;
    n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid act=%b exp=0", bus.OUT_VALID); end
    n_cmp++; if (bus.HALTED !== 1'b0) begin n_bad++; $display("FAIL reset_halted act=%b exp=0", bus.HALTED); end
    act = obs();
    n_cmp++; if (act !== empty) begin n_bad++; $display("FAIL reset_outputs act=%h exp=%h", act, empty); end
    n_cmp++; if (bus.IN_READY !== 1'b1) begin n_bad++; $display("FAIL reset_ready act=%b exp=1", bus.IN_READY); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    drive(1, 16'h5445); #1;
    n_cmp++; if (bus.IN_READY !== 1'b1) begin n_bad++; $display("FAIL addi_ready act=%b exp=1", bus.IN_READY); end
    sb_q.push_back(mk(1, 2, 0, 6'd5, 0, 4'b1010, 3'd0, 3'd4, 0, 0));
    tick();
    drive(0, 16'h0); #1;
    n_cmp++; if (bus.OUT_VALID !== 1'b1) begin n_bad++; $display("FAIL addi_valid act=%b exp=1", bus.OUT_VALID); end
    act = obs(); ex1 = sb_q.pop_front();
    n_cmp++; if (act !== ex1) begin n_bad++; $display("FAIL addi_out act=%h exp=%h", act, ex1); end
    tick(); #1;
    n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL addi_drain act=%b exp=0", bus.OUT_VALID); end
    tick();
  endtask

  // Back-to-back stream with continuous ready: one result per cycle.
  task automatic test_patterns();
    logic [15:0] ins [6];
    exp_t        ex  [6];
    ins[0] = 16'h67AA; ex[0] = mk(6, 3, 0, 6'h2A, 6'h00, 4'b1010, 3'd5, 3'd4, 0, 0);
    ins[1] = 16'h9EB0; ex[1] = mk(0, 7, 2, 6'h00, 6'h30, 4'b0000, 3'd1, 3'd1, 0, 0);
    ins[2] = 16'hB5C1; ex[2] = mk(0, 2, 0, 6'h00, 6'h01, 4'b1000, 3'd0, 3'd3, 0, 0);
    ins[3] = 16'hF2B9; ex[3] = mk(7, 1, 2, 6'h00, 6'h00, 4'b0010, 3'd1, 3'd4, 0, 0);
    ins[4] = 16'hA8C3; ex[4] = mk(0, 4, 0, 6'h00, 6'h03, 4'b1000, 3'd0, 3'd2, 0, 0);
    ins[5] = 16'h0FF2; ex[5] = mk(0, 0, 0, 6'h00, 6'h00, 4'b0000, 3'd0, 3'd4, 0, 0);
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) drive(1, ins[i]); else drive(0, 16'h0);
      #1;
      if (i > 0) begin
        act = obs(); ex1 = sb_q.pop_front();
        n_cmp++; if (bus.OUT_VALID !== 1'b1 || act !== ex1) begin
          n_bad++; $display("FAIL pattern_%0d act=%h v=%b exp=%h", i-1, act, bus.OUT_VALID, ex1); end
      end
      if (i < 6) begin
        n_cmp++; if (bus.IN_READY !== 1'b1) begin n_bad++; $display("FAIL pattern_ready_%0d act=%b exp=1", i, bus.IN_READY); end
        sb_q.push_back(ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    // LB r3 then ADD reading r3: exactly one bubble.
    drive(1, 16'h22C0); #1;
    sb_q.push_back(mk(3, 1, 0, 0, 0, 4'b1110, 3'd0, 3'd4, 0, 0));
    tick();
    drive(1, 16'hF660); #1;
    act = obs(); ex1 = sb_q.pop_front();
    n_cmp++; if (act !== ex1) begin n_bad++; $display("FAIL lu_lb_out act=%h exp=%h", act, ex1); end
    n_cmp++; if (bus.IN_READY !== 1'b0) begin n_bad++; $display("FAIL lu_interlock act=%b exp=0", bus.IN_READY); end
    tick(); #1;
    n_cmp++; if (bus.OUT_VALID !== 1'b0 || bus.LD !== 1'b0) begin
      n_bad++; $display("FAIL lu_bubble act=%b/%b exp=0/0", bus.OUT_VALID, bus.LD); end
    n_cmp++; if (bus.IN_READY !== 1'b1) begin n_bad++; $display("FAIL lu_resume act=%b exp=1", bus.IN_READY); end
    sb_q.push_back(mk(4, 3, 1, 0, 0, 4'b0010, 3'd0, 3'd4, 0, 0));
    tick();
    drive(0, 16'h0); #1;
    act = obs(); ex1 = sb_q.pop_front();
    n_cmp++; if (bus.OUT_VALID !== 1'b1 || act !== ex1) begin
      n_bad++; $display("FAIL lu_add_out act=%h v=%b exp=%h", act, bus.OUT_VALID, ex1); end
    tick();
    // LB r0 then reader of r0: no bubble.
    drive(1, 16'h2200); #1;
    sb_q.push_back(mk(0, 1, 0, 0, 0, 4'b1110, 3'd0, 3'd4, 0, 0));
    tick();
    drive(1, 16'hF060); #1;
    act = obs(); ex1 = sb_q.pop_front();
    n_cmp++; if (act !== ex1) begin n_bad++; $display("FAIL lu0_lb_out act=%h exp=%h", act, ex1); end
    n_cmp++; if (bus.IN_READY !== 1'b1) begin n_bad++; $display("FAIL lu0_no_bubble act=%b exp=1", bus.IN_READY); end
    sb_q.push_back(mk(4, 0, 1, 0, 0, 4'b0010, 3'd0, 3'd4, 0, 0));
    tick();
    drive(0, 16'h0); #1;
    act = obs(); ex1 = sb_q.pop_front();
    n_cmp++; if (bus.OUT_VALID !== 1'b1 || act !== ex1) begin
      n_bad++; $display("FAIL lu0_add_out act=%h v=%b exp=%h", act, bus.OUT_VALID, ex1); end
    tick();
  endtask

  task automatic test_stall();
    bus.OUT_READY = 1'b0;
    drive(1, 16'h7A8F); #1;
    sb_q.push_back(mk(2, 5, 0, 6'h0F, 0, 4'b1010, 3'd6, 3'd4, 0, 0));
    tick();
    drive(1, 16'h4707);
    for (int k = 0; k < 3; k++) begin
      #1;
      act = obs();
      n_cmp++; if (bus.OUT_VALID !== 1'b1 || act !== sb_q[0]) begin
        n_bad++; $display("FAIL stall_hold_%0d act=%h v=%b exp=%h", k, act, bus.OUT_VALID, sb_q[0]); end
      n_cmp++; if (bus.IN_READY !== 1'b0) begin n_bad++; $display("FAIL stall_ready_%0d act=%b exp=0", k, bus.IN_READY); end
      tick();
    end
    bus.OUT_READY = 1'b1; #1;
    n_cmp++; if (bus.IN_READY !== 1'b1) begin n_bad++; $display("FAIL stall_release act=%b exp=1", bus.IN_READY); end
    void'(sb_q.pop_front());
    sb_q.push_back(mk(0, 3, 4, 6'd7, 0, 4'b1001, 3'd0, 3'd4, 0, 0));
    tick();
    drive(0, 16'h0); #1;
    act = obs(); ex1 = sb_q.pop_front();
    n_cmp++; if (bus.OUT_VALID !== 1'b1 || act !== ex1) begin
      n_bad++; $display("FAIL stall_store_out act=%h v=%b exp=%h", act, bus.OUT_VALID, ex1); end
    tick(); #1;
    n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL stall_single act=%b exp=0", bus.OUT_VALID); end
    tick();
  endtask

  task automatic test_flush();
    exp_t empty;
    empty = mk(0, 0, 0, 0, 0, 4'b0000, 0, 3'd4, 0, 0);
    drive(1, 16'h8A45); #1;
    sb_q.push_back(mk(0, 5, 1, 0, 6'd5, 4'b0000, 3'd1, 3'd0, 0, 0));
    tick();
    drive(1, 16'h5445); bus.FLUSH = 1'b1; #1;
    n_cmp++; if (bus.IN_READY !== 1'b0) begin n_bad++; $display("FAIL flush_ready act=%b exp=0", bus.IN_READY); end
    act = obs(); ex1 = sb_q.pop_front();
    n_cmp++; if (act !== ex1) begin n_bad++; $display("FAIL flush_beq_out act=%h exp=%h", act, ex1); end
    tick();
    drive(0, 16'h0); bus.FLUSH = 1'b0; #1;
    act = obs();
    n_cmp++; if (bus.OUT_VALID !== 1'b0 || act !== empty) begin
      n_bad++; $display("FAIL flush_killed act=%h v=%b exp=%h", act, bus.OUT_VALID, empty); end
    tick();
  endtask

  task automatic test_halt();
    drive(1, 16'h0001); #1;
    n_cmp++; if (bus.IN_READY !== 1'b1) begin n_bad++; $display("FAIL halt_ready act=%b exp=1", bus.IN_READY); end
    sb_q.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 3'd0, 3'd4, 1, 0));
    tick();
    drive(1, 16'h5445); #1;
    act = obs(); ex1 = sb_q.pop_front();
    n_cmp++; if (bus.OUT_VALID !== 1'b1 || act !== ex1) begin
      n_bad++; $display("FAIL halt_out act=%h v=%b exp=%h", act, bus.OUT_VALID, ex1); end
    n_cmp++; if (bus.HALTED !== 1'b1 || bus.IN_READY !== 1'b0) begin
      n_bad++; $display("FAIL halt_set act=%b/%b exp=1/0", bus.HALTED, bus.IN_READY); end
    tick();
    for (int k = 0; k < 12; k++) begin
      #1;
      n_cmp++; if (bus.IN_READY !== 1'b0 || bus.HALTED !== 1'b1 || bus.OUT_VALID !== 1'b0) begin
        n_bad++; $display("FAIL halt_sticky_%0d rdy=%b halted=%b v=%b exp=0/1/0", k, bus.IN_READY, bus.HALTED, bus.OUT_VALID); end
      tick();
    end
    drive(0, 16'h0); rst_n = 1'b0; #1;
    n_cmp++; if (bus.HALTED !== 1'b0 || bus.OUT_VALID !== 1'b0) begin
      n_bad++; $display("FAIL halt_reset act=%b/%b exp=0/0", bus.HALTED, bus.OUT_VALID); end
    rst_n = 1'b1;
    tick();
    // Speculative HALT squashed by a flush.
    bus.OUT_READY = 1'b0;
    drive(1, 16'h0001); #1;
    sb_q.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 3'd0, 3'd4, 1, 0));
    tick();
    drive(0, 16'h0); bus.FLUSH = 1'b1; #1;
    act = obs(); ex1 = sb_q.pop_front();
    n_cmp++; if (act !== ex1 || bus.HALTED !== 1'b1) begin
      n_bad++; $display("FAIL hflush_pre act=%h halted=%b exp=%h/1", act, bus.HALTED, ex1); end
    tick();
    bus.FLUSH = 1'b0; #1;
    n_cmp++; if (bus.HALTED !== 1'b0 || bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin
      n_bad++; $display("FAIL hflush_clear halted=%b v=%b rdy=%b exp=0/0/1", bus.HALTED, bus.OUT_VALID, bus.IN_READY); end
    bus.OUT_READY = 1'b1;
    tick();
  endtask

  task automatic test_illegal();
    drive(1, 16'h3000); #1;
    sb_q.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 3'd0, 3'd4, 0, TRAP));
    tick();
    drive(0, 16'h0); #1;
    act = obs(); ex1 = sb_q.pop_front();
    n_cmp++; if (bus.OUT_VALID !== 1'b1 || act !== ex1) begin
      n_bad++; $display("FAIL illegal_out act=%h v=%b exp=%h", act, bus.OUT_VALID, ex1); end
    n_cmp++; if (bus.HALTED !== TRAP) begin n_bad++; $display("FAIL illegal_halted act=%b exp=%b", bus.HALTED, TRAP); end
    tick(); #1;
    n_cmp++; if (bus.IN_READY !== ~TRAP) begin n_bad++; $display("FAIL illegal_ready act=%b exp=%b", bus.IN_READY, ~TRAP); end
    rst_n = 1'b0; #1; rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_patterns();
    test_load_use();
    test_stall();
    test_flush();
    test_halt();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parameterised instruction-decode stage that sits between fetch and the register-file/ALU stage of the toy processor.
- Decodes the 4-bit-opcode ISA into datapath controls and holds them in a single pipeline slot with valid/ready handshakes on both sides.
- Adds three things the combinational decoder lacks: a load-use interlock bubble, sticky halt, and branch flush.

Parameters:
- REG_AW, 3: register address width; drives DR/SA/SB widths.
- IMM_W, 6: immediate/offset field width. Must satisfy IMM_W >= REG_AW+3.
- INST_W, derived localparam = 4 + 2*REG_AW + IMM_W (16 by default); not overridable.

Ports:
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  INST is valid.
- IN_READY  out  1  stage accepts INST this cycle.
- INST  in  INST_W  instruction word.
- FLUSH  in  1  taken branch; kill slot contents.
- OUT_VALID  out  1  slot holds a decoded instruction.
- OUT_READY  in  1  downstream consumes slot.
- DR, SA, SB  out  REG_AW each  destination/source registers.
- IMM, OFF  out  IMM_W each  immediate / branch offset.
- MB, MD, LD, MW  out  1 each  B-mux select, data-mux select, register write, memory write.
- FS  out  3  ALU function.
- BS  out  3  branch select: 0 BEQ, 1 BNE, 2 BGEZ-type, 3 BLTZ-type, 4 none.
- HALT  out  1  slot holds a HALT.
- HALTED  out  1  sticky halt state.
- ILLEGAL  out  1  optional feature only; see Optional Feature.

Behaviour:
- Field positions: opcode = INST[INST_W-1 -: 4]; SA next REG_AW bits; SB/I-type DR next REG_AW bits; IMM/OFF = low IMM_W bits. R-type DR = IMM field[REG_AW+2:3]; R-type FS = INST[2:0].
- Opcode map:
  - 0000: NOP, or HALT when INST[2:0]=001.
  - 0010 LB: MB=1, MD=1, LD=1.
  - 0100 SB: MB=1, MW=1.
  - 0101 ADDI: FS=000.
  - 0110 ANDI: FS=101.
  - 0111 ORI: FS=110. ADDI/ANDI/ORI all set MB=1, LD=1.
  - 1111: R-type, LD=1.
  - 1000 / 1001: BS=0 / 1, FS=001, SA and SB used.
  - 1010 / 1011: BS=2 / 3, MB=1, IMM=0, SA only.
  - Other opcodes: NOP.
- Unused fields decode to 0.
- Slot-empty outputs: whenever OUT_VALID=0, all control outputs are 0 and BS=4. Downstream never sees a stray LD/MW.
- Reset values: OUT_VALID=0, HALTED=0, empty-slot output values, ILLEGAL=0.
- Latency: 1 cycle. An instruction accepted at edge N appears at the outputs after edge N.
- IN_READY = !HALTED & !FLUSH & !interlock & (!OUT_VALID | OUT_READY). Acceptance is IN_VALID & IN_READY.
- Slot transfer: when OUT_VALID & OUT_READY and nothing is accepted, the slot empties next cycle.
- Interlock (combinational):
  - Asserts when the slot holds LB with DR != 0, and the incoming INST reads that register.
  - SA is read by every opcode except 0000/illegal. SB is read by 0100, 1111, 1000, 1001.
  - Result is exactly one bubble: the LB leaves, the slot goes empty for one cycle, and the consumer is accepted on the next cycle.
  - A match on register 0 never interlocks.
- FLUSH:
  - At the next edge OUT_VALID goes to 0 and no input is accepted.
  - If the flushed slot held HALT, HALTED also clears (squashed speculative halt).
  - FLUSH has priority over acceptance and over HALTED set.
- Halt:
  - Accepting a HALT sets HALTED at the same edge.
  - IN_READY then stays 0 until reset or until the HALT is flushed.
  - The HALT is presented once with HALT=1 and leaves normally on OUT_READY. After that, HALTED stays 1.
- Stall: with OUT_VALID=1 and OUT_READY=0, all outputs are held stable.
- Reset mid-operation: asynchronously clears the slot and HALTED with no further output.

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
- When defined: an unlisted opcode decodes as NOP but drives ILLEGAL=1 while in the slot, and sets HALTED on acceptance exactly as HALT does. FLUSH of it clears HALTED.
- When undefined: the ILLEGAL port is still present and tied 0; unlisted opcodes are plain NOPs.

Decomposition:
- Shared package decode_pkg holds: opcode constants (OP_NOP, OP_LB, OP_SB, OP_ADDI, OP_ANDI, OP_ORI, OP_ALU, OP_BEQ, OP_BNE, OP_BR2, OP_BR3), FS constants (FS_ADD=0, FS_SUB=1, FS_AND=5, FS_OR=6), BS constants (BS_NONE=4, ...), and a packed control-bundle typedef.
- One sub-module, decode_comb: purely combinational INST -> control bundle, plus "reads SA/SB" flags.
- decode_stage owns the slot register, handshake, interlock, halt and flush.

Test Plan:
- ADDI r1 <- r2+5 (0x5445), OUT_READY=1: one cycle later OUT_VALID=1, DR=1, SA=2, IMM=5, MB=1, LD=1, BS=4.
- LB r3 <- [r1+0] (0x22C0), then ADD r4 <- r3+r1 (0xF660), continuous ready: LB out, one bubble cycle with OUT_VALID=0, then ADD with DR=4, FS=0. The same sequence with LB DR=0 produces no bubble.
- OUT_READY held 0 for 3 cycles with the slot full: outputs stable, IN_READY=0, no input consumed.
- HALT (0x0001) accepted: HALT=1 for its slot cycle, HALTED=1, IN_READY stays 0 for 10+ cycles; RESET_N pulse clears both.
- BEQ in slot, FLUSH=1 together with IN_VALID: next cycle OUT_VALID=0 and the input is not consumed. HALT in slot + FLUSH: HALTED returns to 0.
- With DECODE_ILLEGAL_TRAP_EN, opcode 0x3 gives ILLEGAL=1 and HALTED=1. Without it: NOP with LD=MW=0 and HALTED=0.
